spi_line_fill: RTL and testbench

- Cache line-fill engine that sits directly upstream of the 256x16 cache data RAM.
- On a miss request it issues a SPI flash READ (0x03) for one cache line and shifts the data in serially.
- It packs the data into 16-bit words and writes each word into the RAM through the RAM's single port (EN/WE/A/Di).
- The cache controller holds off RAM reads while fill_busy is high.

---
 rtl/spi_line_fill.sv | 209 ++++++++++++++++++++
 tb/tb_spi_line_fill.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_line_fill.sv
// spi_line_fill: fills one cache line from SPI flash (READ 0x03) into the
// 256x16 cache data RAM. Each line is packed into little-endian 16-bit words.
module spi_line_fill #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SCK_DIV    = 1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        fill_req,
    input  logic [23:0] fill_addr,
    input  logic [7:0]  fill_base,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        sck,
    output logic        csb,
    output logic        mosi,
    input  logic        miso,
    output logic        ram_en,
    output logic [1:0]  ram_we,
    output logic [7:0]  ram_a,
    output logic [15:0] ram_di
);

    localparam int unsigned NBITS      = 32 + 16 * LINE_WORDS;
    localparam int unsigned CNT_W      = $clog2(NBITS);
    localparam int unsigned DIV_W      = 4;
    localparam int unsigned GAP_W      = 5;
    localparam int unsigned ALIGN_BITS = $clog2(LINE_WORDS * 2);
    localparam logic [23:0] ADDR_MASK  = ~((24'd1 << ALIGN_BITS) - 24'd1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

    state_e             state_q, state_d;
    logic               csb_q, csb_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ram_en_q, ram_en_d;
    logic [1:0]         ram_we_q, ram_we_d;
    logic [7:0]         ram_a_q, ram_a_d;
    logic [15:0]        ram_di_q, ram_di_d;
    logic [31:0]        tx_q, tx_d;
    logic [15:0]        sreg_q, sreg_d;
    logic [7:0]         base_q, base_d;
    logic [7:0]         word_idx_q, word_idx_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               wr_pend_q, wr_pend_d;

    logic div_tc;
    logic sck_fall;
    logic last_bit;
    logic gap_tc;

    assign div_tc   = (div_q == DIV_W'(SCK_DIV - 1));
    assign sck_fall = (state_q == S_SHIFT) && div_tc && sck_q;
    assign last_bit = (bit_cnt_q == CNT_W'(NBITS - 1));
    assign gap_tc   = (gap_cnt_q == GAP_W'(2 * SCK_DIV - 1));

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: IDLE -> SHIFT -> GAP -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (fill_req)             state_d = S_SHIFT;
            S_SHIFT: if (sck_fall && last_bit) state_d = S_GAP;
            S_GAP:   if (gap_tc)               state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: SPI shifting, word packing, RAM write pulse
    always_comb begin
        csb_d      = csb_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ram_en_d   = 1'b0;
        ram_we_d   = 2'b00;
        ram_a_d    = ram_a_q;
        ram_di_d   = ram_di_q;
        tx_d       = tx_q;
        sreg_d     = sreg_q;
        base_d     = base_q;
        word_idx_d = word_idx_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        gap_cnt_d  = gap_cnt_q;
        wr_pend_d  = 1'b0;

        // A completed word is written one cycle after its last bit is sampled
        if (wr_pend_q) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 2'b11;
            ram_a_d    = base_q + word_idx_q;
            ram_di_d   = {sreg_q[7:0], sreg_q[15:8]};
            word_idx_d = word_idx_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fill_req) begin
                    tx_d       = {8'h03, fill_addr & ADDR_MASK};
                    mosi_d     = 1'b0;
                    base_d     = fill_base;
                    csb_d      = 1'b0;
                    busy_d     = 1'b1;
                    sck_d      = 1'b0;
                    div_d      = '0;
                    bit_cnt_d  = '0;
                    word_idx_d = '0;
                    sreg_d     = '0;
                end
            end
            S_SHIFT: begin
                if (div_tc) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    if (!sck_q) begin
                        // Rising SCK: sample miso, data phase only
                        if (bit_cnt_q >= CNT_W'(32)) begin
                            sreg_d    = {sreg_q[14:0], miso};
                            wr_pend_d = (bit_cnt_q[3:0] == 4'hF);
                        end
                    end else if (last_bit) begin
                        csb_d     = 1'b1;
                        mosi_d    = 1'b0;
                        gap_cnt_d = '0;
                    end else begin
                        // Falling SCK: advance to next outgoing bit
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = {tx_q[30:0], 1'b0};
                        mosi_d    = tx_q[30];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_tc) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            csb_q      <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 2'b00;
            ram_a_q    <= '0;
            ram_di_q   <= '0;
            tx_q       <= '0;
            sreg_q     <= '0;
            base_q     <= '0;
            word_idx_q <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            gap_cnt_q  <= '0;
            wr_pend_q  <= 1'b0;
        end else begin
            csb_q      <= csb_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_a_q    <= ram_a_d;
            ram_di_q   <= ram_di_d;
            tx_q       <= tx_d;
            sreg_q     <= sreg_d;
            base_q     <= base_d;
            word_idx_q <= word_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            gap_cnt_q  <= gap_cnt_d;
            wr_pend_q  <= wr_pend_d;
        end
    end

    assign csb       = csb_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign fill_busy = busy_q;
    assign fill_done = done_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_a     = ram_a_q;
    assign ram_di    = ram_di_q;

endmodule

// File: tb/tb_spi_line_fill.sv
// Bench for spi_line_fill: instance 0 uses SCK_DIV=1, instance 1 uses SCK_DIV=3.
// A flash model per instance serves bytes seed, seed+1, ... after the command.
module tb_spi_line_fill;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;

    logic        fill_req_r  [2] = '{1'b0, 1'b0};
    logic [23:0] fill_addr_r [2] = '{24'h0, 24'h0};
    logic [7:0]  fill_base_r [2] = '{8'h0, 8'h0};
    logic        miso_r      [2] = '{1'b0, 1'b0};
    logic        busy_w [2];
    logic        done_w [2];
    logic        sck_w  [2];
    logic        csb_w  [2];
    logic        mosi_w [2];
    logic        ram_en_w [2];
    logic [1:0]  ram_we_w [2];
    logic [7:0]  ram_a_w  [2];
    logic [15:0] ram_di_w [2];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    spi_line_fill #(.LINE_WORDS(8), .SCK_DIV(1)) u_dut (
        .CLK(CLK), .RESETn(RESETn),
        .fill_req(fill_req_r[0]), .fill_addr(fill_addr_r[0]), .fill_base(fill_base_r[0]),
        .fill_busy(busy_w[0]), .fill_done(done_w[0]),
        .sck(sck_w[0]), .csb(csb_w[0]), .mosi(mosi_w[0]), .miso(miso_r[0]),
        .ram_en(ram_en_w[0]), .ram_we(ram_we_w[0]), .ram_a(ram_a_w[0]), .ram_di(ram_di_w[0])
    );

    spi_line_fill #(.LINE_WORDS(8), .SCK_DIV(3)) u_dut3 (
        .CLK(CLK), .RESETn(RESETn),
        .fill_req(fill_req_r[1]), .fill_addr(fill_addr_r[1]), .fill_base(fill_base_r[1]),
        .fill_busy(busy_w[1]), .fill_done(done_w[1]),
        .sck(sck_w[1]), .csb(csb_w[1]), .mosi(mosi_w[1]), .miso(miso_r[1]),
        .ram_en(ram_en_w[1]), .ram_we(ram_we_w[1]), .ram_a(ram_a_w[1]), .ram_di(ram_di_w[1])
    );

    // Monitor / flash model state, per instance
    int          cyc = 0;
    int          low_run [2] = '{0, 0};
    int          last_low [2], falls [2], dones [2], nwr [2], bad_we [2];
    int          t_rise [2], t_done [2], t_fall [2], t_lastwr [2];
    int          run [2], bad_sck [2], levels [2], bidx [2];
    logic [31:0] cmd [2];
    logic [7:0]  seed [2];
    logic [7:0]  wa [2][64];
    logic [15:0] wd [2][64];
    logic        prev_csb [2] = '{1'b1, 1'b1};
    logic        prev_sck [2] = '{1'b0, 1'b0};

    // Flash model and bus monitor, sampled on the falling CLK edge
    always @(negedge CLK) begin : mon
        int j;
        int k;
        logic [7:0] b;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            k = (i == 0) ? 1 : 3;
            if (!csb_w[i] && prev_csb[i]) begin
                bidx[i] = 0; falls[i]++; t_fall[i] = cyc; run[i] = 1;
            end else if (!csb_w[i]) begin
                if (sck_w[i] && !prev_sck[i] && bidx[i] < 32) cmd[i] = {cmd[i][30:0], mosi_w[i]};
                if (!sck_w[i] && prev_sck[i]) bidx[i]++;
                if (sck_w[i] == prev_sck[i]) run[i]++;
                else begin
                    if (run[i] != k) bad_sck[i]++;
                    levels[i]++; run[i] = 1;
                end
            end else if (!prev_csb[i]) begin
                t_rise[i] = cyc; last_low[i] = low_run[i];
                if (run[i] != k) bad_sck[i]++;
                levels[i]++;
            end
            if (!csb_w[i]) low_run[i]++; else low_run[i] = 0;
            if (bidx[i] < 32) miso_r[i] = 1'b0;
            else begin
                j = bidx[i] - 32;
                b = seed[i] + 8'(j / 8);
                miso_r[i] = b[7 - (j % 8)];
            end
            if (done_w[i]) begin dones[i]++; t_done[i] = cyc; end
            if (ram_en_w[i]) begin
                if (nwr[i] < 64) begin wa[i][nwr[i]] = ram_a_w[i]; wd[i][nwr[i]] = ram_di_w[i]; end
                if (ram_we_w[i] != 2'b11) bad_we[i]++;
                nwr[i]++; t_lastwr[i] = cyc;
            end
            prev_csb[i] = csb_w[i];
            prev_sck[i] = sck_w[i];
        end
    end

    // Expected little-endian word k when the flash returns seed, seed+1, ...
    function automatic logic [15:0] exp_word(input logic [7:0] s, input int k);
        logic [7:0] lo, hi;
        lo = s + 8'(2 * k);
        hi = s + 8'(2 * k + 1);
        return {hi, lo};
    endfunction

    task automatic clear_mon(input int i, input logic [7:0] s);
        falls[i] = 0; dones[i] = 0; nwr[i] = 0; bad_we[i] = 0; bad_sck[i] = 0;
        levels[i] = 0; last_low[i] = 0; cmd[i] = '0; seed[i] = s;
        t_rise[i] = 0; t_done[i] = 0; t_fall[i] = 0; t_lastwr[i] = 0;
    endtask

    task automatic start_fill(input int i, input logic [23:0] a, input logic [7:0] base, input logic [7:0] s);
        @(negedge CLK);
        clear_mon(i, s);
        fill_req_r[i] = 1'b1; fill_addr_r[i] = a; fill_base_r[i] = base;
        @(negedge CLK);
        fill_req_r[i] = 1'b0;
    endtask

    task automatic wait_dones(input int i, input int n, input int budget);
        int c = 0;
        while (dones[i] < n && c < budget) begin @(negedge CLK); c++; end
        repeat (4) @(negedge CLK);
        checks++;
        if (dones[i] < n) begin
            errors++;
            $display("FAIL wait_done[%0d]: got %0d done pulses, required %0d within %0d cycles", i, dones[i], n, budget);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({csb_w[i], sck_w[i], mosi_w[i], busy_w[i], done_w[i], ram_en_w[i], ram_we_w[i]} !== 8'b1000_0000) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: csb,sck,mosi,busy,done,en,we = %b%b%b%b%b%b%b, required 10000000", i,
                         csb_w[i], sck_w[i], mosi_w[i], busy_w[i], done_w[i], ram_en_w[i], ram_we_w[i]);
            end
            checks++;
            if (ram_a_w[i] !== 8'h00 || ram_di_w[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_ram[%0d]: a=%h di=%h, required 00/0000", i, ram_a_w[i], ram_di_w[i]);
            end
        end
    endtask

    task automatic test_basic;
        start_fill(0, 24'h012345, 8'h10, 8'h00);
        wait_dones(0, 1, 600);
        checks++;
        if (cmd[0] !== 32'h03012340) begin errors++; $display("FAIL basic_cmd: got %h, required 03012340", cmd[0]); end
        checks++;
        if (nwr[0] !== 8) begin errors++; $display("FAIL basic_nwr: got %0d, required 8", nwr[0]); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (wa[0][k] !== 8'(8'h10 + k) || wd[0][k] !== exp_word(8'h00, k)) begin
                errors++;
                $display("FAIL basic_word%0d: a=%h d=%h, required a=%h d=%h", k, wa[0][k], wd[0][k], 8'(8'h10 + k), exp_word(8'h00, k));
            end
        end
        checks++;
        if (last_low[0] !== 320) begin errors++; $display("FAIL basic_csb_low: got %0d, required 320", last_low[0]); end
        checks++;
        if (dones[0] !== 1 || falls[0] !== 1) begin errors++; $display("FAIL basic_done: dones=%0d falls=%0d, required 1/1", dones[0], falls[0]); end
        checks++;
        if (t_done[0] - t_rise[0] !== 2) begin errors++; $display("FAIL basic_gap: got %0d, required 2", t_done[0] - t_rise[0]); end
        checks++;
        if (t_lastwr[0] < t_rise[0]) begin errors++; $display("FAIL basic_last_wr_in_gap: wr at %0d, csb rise at %0d", t_lastwr[0], t_rise[0]); end
        checks++;
        if (bad_we[0] !== 0 || busy_w[0] !== 1'b0) begin errors++; $display("FAIL basic_we_busy: bad_we=%0d busy=%b, required 0/0", bad_we[0], busy_w[0]); end
    endtask

    task automatic test_wrap;
        start_fill(0, 24'h000000, 8'hFC, 8'h20);
        wait_dones(0, 1, 600);
        checks++;
        if (nwr[0] !== 8) begin errors++; $display("FAIL wrap_nwr: got %0d, required 8", nwr[0]); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (wa[0][k] !== 8'(8'hFC + k) || wd[0][k] !== exp_word(8'h20, k)) begin
                errors++;
                $display("FAIL wrap_word%0d: a=%h d=%h, required a=%h d=%h", k, wa[0][k], wd[0][k], 8'(8'hFC + k), exp_word(8'h20, k));
            end
        end
    endtask

    task automatic test_divider;
        start_fill(1, 24'h00010F, 8'h40, 8'h80);
        wait_dones(1, 1, 1500);
        checks++;
        if (cmd[1] !== 32'h03000100) begin errors++; $display("FAIL div_cmd: got %h, required 03000100", cmd[1]); end
        checks++;
        if (last_low[1] !== 960) begin errors++; $display("FAIL div_csb_low: got %0d, required 960", last_low[1]); end
        checks++;
        if (levels[1] !== 320 || bad_sck[1] !== 0) begin errors++; $display("FAIL div_sck_levels: levels=%0d bad=%0d, required 320/0", levels[1], bad_sck[1]); end
        checks++;
        if (t_done[1] - t_rise[1] !== 6) begin errors++; $display("FAIL div_gap: got %0d, required 6", t_done[1] - t_rise[1]); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (wa[1][k] !== 8'(8'h40 + k) || wd[1][k] !== exp_word(8'h80, k)) begin
                errors++;
                $display("FAIL div_word%0d: a=%h d=%h, required a=%h d=%h", k, wa[1][k], wd[1][k], 8'(8'h40 + k), exp_word(8'h80, k));
            end
        end
    endtask

    task automatic test_busy_ignore;
        start_fill(0, 24'h00FF00, 8'h30, 8'h50);
        repeat (50) @(negedge CLK);
        checks++;
        if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL busy_mid_shift: got %b, required 1", busy_w[0]); end
        fill_req_r[0] = 1'b1; fill_addr_r[0] = 24'hABCDE0; fill_base_r[0] = 8'h99;
        @(negedge CLK);
        fill_req_r[0] = 1'b0;
        wait_dones(0, 1, 600);
        repeat (20) @(negedge CLK);
        checks++;
        if (cmd[0] !== 32'h0300FF00) begin errors++; $display("FAIL busy_cmd: got %h, required 0300FF00", cmd[0]); end
        checks++;
        if (dones[0] !== 1 || falls[0] !== 1 || nwr[0] !== 8) begin
            errors++;
            $display("FAIL busy_single: dones=%0d falls=%0d nwr=%0d, required 1/1/8", dones[0], falls[0], nwr[0]);
        end
        checks++;
        if (wa[0][0] !== 8'h30 || wd[0][7] !== exp_word(8'h50, 7)) begin
            errors++;
            $display("FAIL busy_data: a0=%h d7=%h, required 30/%h", wa[0][0], wd[0][7], exp_word(8'h50, 7));
        end
    endtask

    task automatic test_async_reset;
        int c = 0;
        start_fill(0, 24'h000000, 8'h60, 8'h00);
        while (nwr[0] < 3 && c < 400) begin @(negedge CLK); c++; end
        repeat (8) @(negedge CLK);
        #2 RESETn = 1'b0;
        #1;
        checks++;
        if ({csb_w[0], sck_w[0], ram_en_w[0], busy_w[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL areset_now: csb,sck,en,busy=%b%b%b%b, required 1000", csb_w[0], sck_w[0], ram_en_w[0], busy_w[0]);
        end
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        repeat (40) @(negedge CLK);
        checks++;
        if (dones[0] !== 0 || nwr[0] !== 3) begin
            errors++;
            $display("FAIL areset_abandon: dones=%0d nwr=%0d, required 0/3", dones[0], nwr[0]);
        end
        start_fill(0, 24'h000020, 8'h70, 8'h11);
        wait_dones(0, 1, 600);
        checks++;
        if (cmd[0] !== 32'h03000020 || nwr[0] !== 8) begin
            errors++;
            $display("FAIL areset_refill: cmd=%h nwr=%0d, required 03000020/8", cmd[0], nwr[0]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (wa[0][k] !== 8'(8'h70 + k) || wd[0][k] !== exp_word(8'h11, k)) begin
                errors++;
                $display("FAIL areset_word%0d: a=%h d=%h, required a=%h d=%h", k, wa[0][k], wd[0][k], 8'(8'h70 + k), exp_word(8'h11, k));
            end
        end
    endtask

    task automatic test_back_to_back;
        int c = 0;
        @(negedge CLK);
        clear_mon(0, 8'h00);
        fill_req_r[0] = 1'b1; fill_addr_r[0] = 24'h000040; fill_base_r[0] = 8'h00;
        while (falls[0] < 2 && c < 800) begin @(negedge CLK); c++; end
        fill_req_r[0] = 1'b0;
        checks++;
        if (falls[0] < 2) begin errors++; $display("FAIL b2b_second_start: falls=%0d, required 2", falls[0]); end
        checks++;
        if (t_fall[0] - t_done[0] !== 1) begin errors++; $display("FAIL b2b_restart_delay: got %0d, required 1", t_fall[0] - t_done[0]); end
        checks++;
        if (t_fall[0] - t_rise[0] < 2) begin errors++; $display("FAIL b2b_csb_high: got %0d, required >=2", t_fall[0] - t_rise[0]); end
        wait_dones(0, 2, 800);
        repeat (10) @(negedge CLK);
        checks++;
        if (nwr[0] !== 16 || falls[0] !== 2 || dones[0] !== 2) begin
            errors++;
            $display("FAIL b2b_totals: nwr=%0d falls=%0d dones=%0d, required 16/2/2", nwr[0], falls[0], dones[0]);
        end
        checks++;
        if (wa[0][15] !== 8'h07 || wd[0][15] !== exp_word(8'h00, 7)) begin
            errors++;
            $display("FAIL b2b_last_word: a=%h d=%h, required 07/%h", wa[0][15], wd[0][15], exp_word(8'h00, 7));
        end
    endtask

    initial begin
        clear_mon(0, 8'h00);
        clear_mon(1, 8'h00);
        repeat (3) @(negedge CLK);
        test_reset;
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        test_basic;
        test_wrap;
        test_divider;
        test_busy_ignore;
        test_async_reset;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
